// File: rtl/reg_wb_arbiter.sv
// reg_wb_arbiter: drives the register-file write port from in-order WB (port A) and a FIFO of
// multi-cycle results (port B) that drain into idle WB slots.
module reg_wb_arbiter #(
    parameter int XLEN         = 32,
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wb_we,
    input  logic [4:0]               wb_rd,
    input  logic [XLEN-1:0]          wb_data,
    input  logic                     mu_valid,
    output logic                     mu_ready,
    input  logic [4:0]               mu_rd,
    input  logic [XLEN-1:0]          mu_data,
    output logic                     rf_we,
    output logic [4:0]               rf_rd,
    output logic [XLEN-1:0]          rf_wdata,
    output logic                     stall_req,
    output logic [31:0]              pending_mask,
    output logic [$clog2(DEPTH):0]   fifo_count
);
    localparam int              AW    = $clog2(DEPTH);
    localparam logic [7:0]      LIMIT = 8'(STARVE_LIMIT);
    localparam logic [AW:0]     FULL  = (AW+1)'(DEPTH);

    logic [4:0]      mem_rd   [DEPTH];
    logic [XLEN-1:0] mem_data [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic [7:0]      starve_cnt, starve_next;
    logic [AW:0]     count_next;
    logic            a_busy, empty, push, pop;

    assign a_busy      = wb_we && wb_rd != 5'd0;
    assign empty       = fifo_count == '0;
    assign mu_ready    = fifo_count != FULL;
    assign push        = mu_valid && mu_ready && mu_rd != 5'd0;
    assign pop         = !a_busy && !empty;
    assign count_next  = fifo_count + (AW+1)'(push) - (AW+1)'(pop);
    assign starve_next = (pop || empty) ? '0 : (starve_cnt >= LIMIT) ? LIMIT : starve_cnt + 8'd1;

    // Port A always wins; the FIFO head only fills otherwise idle slots.
    assign rf_we    = !reset && (a_busy || !empty);
    assign rf_rd    = reset ? '0 : a_busy ? wb_rd : empty ? '0 : mem_rd[rd_ptr];
    assign rf_wdata = reset ? '0 : a_busy ? wb_data : empty ? '0 : mem_data[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            valid      <= '0;
            fifo_count <= '0;
            starve_cnt <= '0;
            stall_req  <= 1'b0;
        end else begin
            rd_ptr     <= rd_ptr + AW'(pop);
            wr_ptr     <= wr_ptr + AW'(push);
            if (push) valid[wr_ptr] <= 1'b1;
            if (pop) valid[rd_ptr] <= 1'b0;
            fifo_count <= count_next;
            starve_cnt <= starve_next;
            stall_req  <= starve_next >= LIMIT || count_next == FULL;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_rd[wr_ptr]   <= mu_rd;
            mem_data[wr_ptr] <= mu_data;
        end
    end

    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < DEPTH; i++)
            if (valid[i]) pending_mask[mem_rd[i]] = 1'b1;
        pending_mask[0] = 1'b0;
    end
endmodule

// File: tb/tb_reg_wb_arbiter.sv
// tb_reg_wb_arbiter: directed scenarios for the writeback arbiter with hand-computed expectations.
module tb_reg_wb_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wb_we = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_data = '0;
    logic        mu_valid = 1'b0;
    logic        mu_ready;
    logic [4:0]  mu_rd = '0;
    logic [31:0] mu_data = '0;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wdata;
    logic        stall_req;
    logic [31:0] pending_mask;
    logic [2:0]  fifo_count;
    int checks = 0;
    int errors = 0;

    reg_wb_arbiter #(.XLEN(32), .DEPTH(4), .STARVE_LIMIT(8)) dut (
        .clk(clk), .reset(reset), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .mu_valid(mu_valid), .mu_ready(mu_ready), .mu_rd(mu_rd), .mu_data(mu_data),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata), .stall_req(stall_req),
        .pending_mask(pending_mask), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'h5;
        cyc; #1;
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_rf_we: got %0h expected 0", rf_we); end
        checks++; if (rf_rd !== 5'd0) begin errors++; $display("FAIL reset_rf_rd: got %0h expected 0", rf_rd); end
        checks++; if (rf_wdata !== 32'd0) begin errors++; $display("FAIL reset_rf_wdata: got %0h expected 0", rf_wdata); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
        checks++; if (pending_mask !== 32'd0) begin errors++; $display("FAIL reset_mask: got %0h expected 0", pending_mask); end
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0h expected 0", stall_req); end
        checks++; if (mu_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0h expected 1", mu_ready); end
        reset = 1'b0; wb_we = 1'b0;
        cyc;
    endtask

    task automatic test_a_only;
        wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'hA5; #1;
        checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL a_only_we: got %0h expected 1", rf_we); end
        checks++; if (rf_rd !== 5'd5) begin errors++; $display("FAIL a_only_rd: got %0d expected 5", rf_rd); end
        checks++; if (rf_wdata !== 32'hA5) begin errors++; $display("FAIL a_only_data: got %0h expected a5", rf_wdata); end
        cyc; wb_we = 1'b0; #1;
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL a_only_count: got %0d expected 0", fifo_count); end
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL a_only_idle: got %0h expected 0", rf_we); end
    endtask

    task automatic test_b_idle;
        mu_valid = 1'b1; mu_rd = 5'd7; mu_data = 32'h1234; #1;
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL b_no_bypass: got %0h expected 0", rf_we); end
        checks++; if (mu_ready !== 1'b1) begin errors++; $display("FAIL b_ready: got %0h expected 1", mu_ready); end
        cyc; mu_valid = 1'b0; #1;
        checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL b_we: got %0h expected 1", rf_we); end
        checks++; if (rf_rd !== 5'd7) begin errors++; $display("FAIL b_rd: got %0d expected 7", rf_rd); end
        checks++; if (rf_wdata !== 32'h1234) begin errors++; $display("FAIL b_data: got %0h expected 1234", rf_wdata); end
        checks++; if (pending_mask !== 32'h80) begin errors++; $display("FAIL b_mask: got %0h expected 80", pending_mask); end
        checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL b_count: got %0d expected 1", fifo_count); end
        cyc; #1;
        checks++; if (pending_mask !== 32'h0) begin errors++; $display("FAIL b_mask_clear: got %0h expected 0", pending_mask); end
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL b_drained_we: got %0h expected 0", rf_we); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL b_drained_count: got %0d expected 0", fifo_count); end
    endtask

    task automatic test_conflict;
        wb_we = 1'b1; wb_rd = 5'd9; wb_data = 32'h99;
        mu_valid = 1'b1; mu_rd = 5'd3; mu_data = 32'h33; #1;
        checks++; if (rf_rd !== 5'd9) begin errors++; $display("FAIL conflict_a0: got %0d expected 9", rf_rd); end
        cyc; mu_valid = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            #1;
            checks++; if (rf_rd !== 5'd9 || rf_we !== 1'b1) begin errors++; $display("FAIL conflict_a cycle %0d: got rd %0d we %0h expected rd 9 we 1", i, rf_rd, rf_we); end
            checks++; if (stall_req !== (i >= 9)) begin errors++; $display("FAIL conflict_stall cycle %0d: got %0h expected %0h", i, stall_req, i >= 9); end
            cyc;
        end
        wb_we = 1'b0; #1;
        checks++; if (rf_we !== 1'b1 || rf_rd !== 5'd3) begin errors++; $display("FAIL conflict_bubble: got we %0h rd %0d expected we 1 rd 3", rf_we, rf_rd); end
        checks++; if (rf_wdata !== 32'h33) begin errors++; $display("FAIL conflict_bubble_data: got %0h expected 33", rf_wdata); end
        checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL conflict_stall_held: got %0h expected 1", stall_req); end
        cyc; #1;
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL conflict_stall_drop: got %0h expected 0", stall_req); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL conflict_count: got %0d expected 0", fifo_count); end
    endtask

    task automatic test_full;
        wb_we = 1'b1; wb_rd = 5'd20; wb_data = 32'h20;
        for (int i = 0; i < 4; i++) begin
            mu_valid = 1'b1; mu_rd = 5'(i + 1); mu_data = 32'h100 + 32'(i + 1); #1;
            checks++; if (mu_ready !== 1'b1) begin errors++; $display("FAIL full_ready_%0d: got %0h expected 1", i, mu_ready); end
            cyc;
        end
        wb_we = 1'b0; mu_valid = 1'b1; mu_rd = 5'd5; mu_data = 32'h105; #1;
        checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL full_count: got %0d expected 4", fifo_count); end
        checks++; if (mu_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %0h expected 0", mu_ready); end
        checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL full_stall: got %0h expected 1", stall_req); end
        checks++; if (pending_mask !== 32'h1E) begin errors++; $display("FAIL full_mask: got %0h expected 1e", pending_mask); end
        checks++; if (rf_rd !== 5'd1 || rf_wdata !== 32'h101) begin errors++; $display("FAIL full_pop1: got rd %0d data %0h expected rd 1 data 101", rf_rd, rf_wdata); end
        cyc; mu_valid = 1'b0; #1;
        checks++; if (fifo_count !== 3'd3) begin errors++; $display("FAIL full_after_pop_count: got %0d expected 3", fifo_count); end
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL full_stall_drop: got %0h expected 0", stall_req); end
        checks++; if (mu_ready !== 1'b1) begin errors++; $display("FAIL full_ready_back: got %0h expected 1", mu_ready); end
        checks++; if (rf_rd !== 5'd2 || rf_wdata !== 32'h102) begin errors++; $display("FAIL full_pop2: got rd %0d data %0h expected rd 2 data 102", rf_rd, rf_wdata); end
        for (int j = 3; j <= 4; j++) begin
            cyc; #1;
            checks++; if (rf_rd !== 5'(j) || rf_we !== 1'b1) begin errors++; $display("FAIL full_pop%0d: got rd %0d we %0h expected rd %0d we 1", j, rf_rd, rf_we, j); end
        end
        cyc; #1;
        checks++; if (rf_we !== 1'b0 || fifo_count !== 3'd0) begin errors++; $display("FAIL full_empty: got we %0h count %0d expected we 0 count 0", rf_we, fifo_count); end
    endtask

    task automatic test_rd0;
        wb_we = 1'b0; mu_valid = 1'b1; mu_rd = 5'd0; mu_data = 32'hDEAD; #1;
        checks++; if (mu_ready !== 1'b1) begin errors++; $display("FAIL rd0_ready: got %0h expected 1", mu_ready); end
        cyc; mu_valid = 1'b0; #1;
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL rd0_count: got %0d expected 0", fifo_count); end
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL rd0_no_write: got %0h expected 0", rf_we); end
        wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'hBEEF; #1;
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL rd0_a_dropped: got %0h expected 0", rf_we); end
        cyc;
        wb_rd = 5'd10; mu_valid = 1'b1; mu_rd = 5'd6; mu_data = 32'h66;
        cyc; mu_valid = 1'b0; wb_rd = 5'd0; #1;
        checks++; if (rf_we !== 1'b1 || rf_rd !== 5'd6) begin errors++; $display("FAIL rd0_drain: got we %0h rd %0d expected we 1 rd 6", rf_we, rf_rd); end
        checks++; if (rf_wdata !== 32'h66) begin errors++; $display("FAIL rd0_drain_data: got %0h expected 66", rf_wdata); end
        cyc; #1;
        checks++; if (fifo_count !== 3'd0 || rf_we !== 1'b0) begin errors++; $display("FAIL rd0_drained: got count %0d we %0h expected 0 0", fifo_count, rf_we); end
        wb_we = 1'b0;
    endtask

    task automatic test_reset_mid;
        wb_we = 1'b1; wb_rd = 5'd21; wb_data = 32'h21;
        for (int i = 0; i < 3; i++) begin
            mu_valid = 1'b1; mu_rd = 5'(11 + i); mu_data = 32'h200 + 32'(i);
            cyc;
        end
        mu_valid = 1'b0; #1;
        checks++; if (fifo_count !== 3'd3) begin errors++; $display("FAIL mid_count_before: got %0d expected 3", fifo_count); end
        checks++; if (pending_mask !== 32'h3800) begin errors++; $display("FAIL mid_mask_before: got %0h expected 3800", pending_mask); end
        reset = 1'b1; wb_we = 1'b0; #1;
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL mid_rf_we: got %0h expected 0", rf_we); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL mid_count: got %0d expected 0", fifo_count); end
        checks++; if (pending_mask !== 32'h0) begin errors++; $display("FAIL mid_mask: got %0h expected 0", pending_mask); end
        checks++; if (mu_ready !== 1'b1) begin errors++; $display("FAIL mid_ready: got %0h expected 1", mu_ready); end
        cyc; reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (rf_we !== 1'b0 || fifo_count !== 3'd0) begin errors++; $display("FAIL mid_after_%0d: got we %0h count %0d expected 0 0", i, rf_we, fifo_count); end
            cyc;
        end
    endtask

    initial begin
        test_reset;
        test_a_only;
        test_b_idle;
        test_conflict;
        test_full;
        test_rd0;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
